// File: rtl/instr_sequencer.sv
// Instruction fetch sequencer: holds the PC, fetches over a req/ack port,
// latches the IR for the opcode decoder and turns decoder flags into strobes.
module instr_sequencer #(
    parameter int unsigned           ADDR_W   = 16,
    parameter int unsigned           INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]     PC_RESET = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    output logic [ADDR_W-1:0]    o_memAddr,
    output logic                 o_memReq,
    input  logic                 i_memAck,
    input  logic [INSTR_W-1:0]   i_memData,
    output logic [3:0]           o_opcode,
    output logic [INSTR_W-1:0]   o_instr,
    input  logic                 i_wrReg,
    input  logic                 i_isHLT,
    output logic                 o_regWrEn,
    output logic                 o_halted,
    input  logic                 i_resume
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 mem_req_q, mem_req_d;
    logic                 halted_q, halted_d;
    logic                 exec_q, exec_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (i_memAck) begin
                    ir_d    = i_memData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // A halt leaves the PC on the HLT word; resume steps past it.
                if (i_isHLT) begin
                    state_d = HALT;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (i_resume) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // State-decoded outputs are registered from the next state so they
        // line up exactly with state_q without a decode after the flops.
        mem_req_d = (state_d == FETCH);
        halted_d  = (state_d == HALT);
        exec_d    = (state_d == EXEC);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            mem_req_q <= 1'b0;
            halted_q  <= 1'b0;
            exec_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mem_req_q <= mem_req_d;
            halted_q  <= halted_d;
            exec_q    <= exec_d;
        end
    end

    // The decoder is combinational on o_opcode, so its flags are only
    // meaningful during the single EXEC cycle.
    assign o_regWrEn = exec_q & i_wrReg & ~i_isHLT;
    assign o_memAddr = pc_q;
    assign o_memReq  = mem_req_q;
    assign o_halted  = halted_q;
    assign o_instr   = ir_q;
    assign o_opcode  = ir_q[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural memory and a tiny
// combinational decoder; a second instance starts at the top of the address space.
module tb_instr_sequencer;

    logic        clk;
    logic        rstn;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [3:0]  opcode;
    logic [15:0] instr;
    logic        wr_reg;
    logic        is_hlt;
    logic        reg_wr_en;
    logic        halted;
    logic        resume;
    logic        stray_ack;
    int unsigned wcnt;

    logic [15:0] w_mem_addr;
    logic        w_mem_req;
    logic [3:0]  w_opcode;
    logic [15:0] w_instr;
    logic        w_reg_wr_en;
    logic        w_halted;
    logic        w_zero;

    int n_cmp;
    int n_err;

    instr_sequencer #(.ADDR_W(16), .INSTR_W(16), .PC_RESET(16'h0000)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .o_memAddr(mem_addr), .o_memReq(mem_req),
        .i_memAck(mem_ack), .i_memData(mem_data),
        .o_opcode(opcode), .o_instr(instr),
        .i_wrReg(wr_reg), .i_isHLT(is_hlt),
        .o_regWrEn(reg_wr_en), .o_halted(halted), .i_resume(resume)
    );

    instr_sequencer #(.ADDR_W(16), .INSTR_W(16), .PC_RESET(16'hFFFF)) dut_w (
        .i_clk(clk), .i_rstn(rstn),
        .o_memAddr(w_mem_addr), .o_memReq(w_mem_req),
        .i_memAck(w_mem_req), .i_memData(16'h1000),
        .o_opcode(w_opcode), .o_instr(w_instr),
        .i_wrReg(w_zero), .i_isHLT(w_zero),
        .o_regWrEn(w_reg_wr_en), .o_halted(w_halted), .i_resume(w_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'hA123;
            16'h0010: mem_word = 16'h3000;
            default:  mem_word = 16'h1000;
        endcase
    endfunction

    function automatic int unsigned wait_states(input logic [15:0] a);
        case (a)
            16'h0005: wait_states = 3;
            16'h0013: wait_states = 10;
            default:  wait_states = 0;
        endcase
    endfunction

    // Memory: ack after wait_states cycles of request; stray_ack injects a
    // spurious ack with a distinctive data word.
    assign mem_ack  = (mem_req && (wcnt == wait_states(mem_addr))) || stray_ack;
    assign mem_data = stray_ack ? 16'hBEEF : mem_word(mem_addr);

    always @(posedge clk) begin
        if (!rstn || !mem_req || mem_ack) wcnt <= 0;
        else                              wcnt <= wcnt + 1;
    end

    // Decoder: opcode A and 3 write registers, opcode 3 is HLT.
    assign is_hlt = (opcode == 4'h3);
    assign wr_reg = (opcode == 4'hA) || (opcode == 4'h3);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; resume = 1'b1; stray_ack = 1'b0;
        tick(); tick();
        resume = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_memReq got=%b exp=0", mem_req); end
        n_cmp++; if (reg_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_regWrEn got=%b exp=0", reg_wr_en); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_memAddr got=%h exp=0000", mem_addr); end
        n_cmp++; if (w_mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL reset_memAddr_w got=%h exp=ffff", w_mem_addr); end
    endtask

    task automatic test_first_fetch;
        rstn = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_err++;
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0000", mem_req, mem_addr); end
        tick();
        n_cmp++; if (opcode !== 4'hA || instr !== 16'hA123) begin n_err++;
            $display("FAIL first_exec_ir got op=%h ir=%h exp op=a ir=a123", opcode, instr); end
        n_cmp++; if (reg_wr_en !== 1'b1 || mem_req !== 1'b0) begin n_err++;
            $display("FAIL first_exec_strobe got wr=%b req=%b exp wr=1 req=0", reg_wr_en, mem_req); end
        tick();
        n_cmp++; if (reg_wr_en !== 1'b0) begin n_err++; $display("FAIL first_strobe_len got=%b exp=0", reg_wr_en); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin n_err++;
            $display("FAIL second_fetch got req=%b addr=%h exp req=1 addr=0001", mem_req, mem_addr); end
    endtask

    task automatic run_to_fetch(input logic [15:0] target);
        int k;
        for (k = 0; k < 200 && !(mem_req === 1'b1 && mem_addr === target); k++) tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== target) begin n_err++;
            $display("FAIL reach_fetch got req=%b addr=%h exp req=1 addr=%h", mem_req, mem_addr, target); end
    endtask

    task automatic test_wait_states;
        run_to_fetch(16'h0005);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || reg_wr_en !== 1'b0) begin n_err++;
                $display("FAIL wait_hold[%0d] got req=%b addr=%h wr=%b exp req=1 addr=0005 wr=0",
                         i, mem_req, mem_addr, reg_wr_en); end
            tick();
        end
        n_cmp++; if (mem_req !== 1'b0 || opcode !== 4'h1 || reg_wr_en !== 1'b0) begin n_err++;
            $display("FAIL wait_exec got req=%b op=%h wr=%b exp req=0 op=1 wr=0", mem_req, opcode, reg_wr_en); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0006) begin n_err++;
            $display("FAIL wait_next got req=%b addr=%h exp req=1 addr=0006", mem_req, mem_addr); end
    endtask

    task automatic test_halt;
        run_to_fetch(16'h0010);
        tick();
        n_cmp++; if (opcode !== 4'h3 || reg_wr_en !== 1'b0 || halted !== 1'b0) begin n_err++;
            $display("FAIL hlt_exec got op=%h wr=%b halted=%b exp op=3 wr=0 halted=0", opcode, reg_wr_en, halted); end
        for (int i = 0; i < 20; i++) begin
            tick();
            stray_ack = (i == 5);
            n_cmp++; if (halted !== 1'b1 || mem_req !== 1'b0 || reg_wr_en !== 1'b0 || mem_addr !== 16'h0010) begin n_err++;
                $display("FAIL halt_hold[%0d] got halted=%b req=%b wr=%b addr=%h exp 1/0/0/0010",
                         i, halted, mem_req, reg_wr_en, mem_addr); end
        end
        stray_ack = 1'b0;
        n_cmp++; if (instr !== 16'h3000) begin n_err++; $display("FAIL halt_stray_ack got ir=%h exp=3000", instr); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0011 || halted !== 1'b0) begin n_err++;
            $display("FAIL resume got req=%b addr=%h halted=%b exp req=1 addr=0011 halted=0", mem_req, mem_addr, halted); end
    endtask

    task automatic test_resume_ignored;
        resume = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b0 || halted !== 1'b0 || opcode !== 4'h1 || mem_addr !== 16'h0011) begin n_err++;
            $display("FAIL resume_in_fetch got req=%b halted=%b op=%h addr=%h exp 0/0/1/0011",
                     mem_req, halted, opcode, mem_addr); end
        tick();
        resume = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || halted !== 1'b0 || mem_addr !== 16'h0012) begin n_err++;
            $display("FAIL resume_in_exec got req=%b halted=%b addr=%h exp 1/0/0012", mem_req, halted, mem_addr); end
    endtask

    task automatic test_reset_mid_fetch;
        run_to_fetch(16'h0013);
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0013) begin n_err++;
            $display("FAIL midfetch_wait got req=%b addr=%h exp req=1 addr=0013", mem_req, mem_addr); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || instr !== 16'h0000) begin n_err++;
            $display("FAIL midfetch_reset got req=%b addr=%h ir=%h exp 0/0000/0000", mem_req, mem_addr, instr); end
        rstn = 1'b1; stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr !== 16'h0000) begin n_err++;
            $display("FAIL idle_ack_ignored got req=%b addr=%h ir=%h exp 1/0000/0000", mem_req, mem_addr, instr); end
        tick();
        n_cmp++; if (instr !== 16'hA123 || reg_wr_en !== 1'b1) begin n_err++;
            $display("FAIL refetch got ir=%h wr=%b exp ir=a123 wr=1", instr, reg_wr_en); end
    endtask

    task automatic test_halt_reset;
        run_to_fetch(16'h0010);
        tick(); tick();
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_again got=%b exp=1", halted); end
        rstn = 1'b0; resume = 1'b1;
        tick();
        rstn = 1'b1; resume = 1'b0;
        n_cmp++; if (halted !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0000) begin n_err++;
            $display("FAIL halt_reset got halted=%b req=%b addr=%h exp 0/0/0000", halted, mem_req, mem_addr); end
    endtask

    task automatic test_pc_wrap;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        n_cmp++; if (w_mem_req !== 1'b1 || w_mem_addr !== 16'hFFFF) begin n_err++;
            $display("FAIL wrap_fetch got req=%b addr=%h exp req=1 addr=ffff", w_mem_req, w_mem_addr); end
        tick();
        n_cmp++; if (w_mem_req !== 1'b0 || w_opcode !== 4'h1) begin n_err++;
            $display("FAIL wrap_exec got req=%b op=%h exp req=0 op=1", w_mem_req, w_opcode); end
        tick();
        n_cmp++; if (w_mem_req !== 1'b1 || w_mem_addr !== 16'h0000) begin n_err++;
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0000", w_mem_req, w_mem_addr); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        w_zero = 1'b0;
        rstn = 1'b0; resume = 1'b0; stray_ack = 1'b0;
        test_reset();
        test_first_fetch();
        test_wait_states();
        test_halt();
        test_resume_ignored();
        test_reset_mid_fetch();
        test_halt_reset();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Front-end sequencer feeding the opcode decoder; the opcode decoder is the downstream consumer.
- Holds the program counter (PC) and fetches 16-bit instructions over a req/ack memory port.
- Latches each instruction in an instruction register (IR) and presents IR[15:12] as the opcode to the decoder.
- Consumes the decoder's register-write and halt flags to generate a one-cycle register-write strobe and to enter and leave halt.

Parameters:
ADDR_W, 16, width of PC and memory address.
INSTR_W, 16, instruction width; opcode is always IR[INSTR_W-1:INSTR_W-4].
PC_RESET, 0, PC value loaded on reset.

Ports:
i_clk  input  1  sole clock; all state updates on rising edge.
i_rstn  input  1  reset; synchronous, active-low.
o_memAddr  output  ADDR_W  fetch address; equals PC.
o_memReq  output  1  fetch request; high only in FETCH.
i_memAck  input  1  fetch complete; i_memData valid in the same cycle.
i_memData  input  INSTR_W  fetched instruction word.
o_opcode  output  4  IR[INSTR_W-1:INSTR_W-4]; goes to the decoder.
o_instr  output  INSTR_W  full IR contents, for operand decode downstream.
i_wrReg  input  1  decoder flag: current opcode writes the register file.
i_isHLT  input  1  decoder flag: current opcode is halt.
o_regWrEn  output  1  register-write strobe, one cycle per qualifying instruction.
o_halted  output  1  high while in HALT.
i_resume  input  1  leave HALT; ignored in every other state.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (i_clk, i_rstn).
- Any rising edge with i_rstn=0 forces: state=IDLE, PC=PC_RESET, IR=0.
- Output values in reset/IDLE: o_memReq=0, o_regWrEn=0, o_halted=0, o_opcode=0, o_instr=0, o_memAddr=PC_RESET.
- State encoding: 4 states, IDLE, FETCH, EXEC, HALT.
- IDLE: transitions to FETCH on the next edge, unconditionally.
- FETCH:
  - o_memReq=1 and o_memAddr=PC.
  - On the edge where i_memAck=1: IR<=i_memData, go to EXEC.
  - Otherwise stay in FETCH; the request is held stable while waiting.
  - Zero-wait ack (ack in the first FETCH cycle) is legal.
- EXEC (exactly one cycle):
  - o_opcode and o_instr reflect the new IR.
  - The decoder is combinational, so i_wrReg and i_isHLT are valid in this same cycle.
  - o_regWrEn = i_wrReg & ~i_isHLT.
  - If i_isHLT=1: go to HALT; PC is unchanged and still points at the HLT instruction.
  - Else: PC<=PC+1 modulo 2^ADDR_W, go to FETCH.
- HALT:
  - o_halted=1, o_memReq=0, o_regWrEn=0; IR is held.
  - On i_resume=1: PC<=PC+1 (wrapping), go to FETCH.
- Outputs are decoded from state; i_wrReg and i_isHLT are ignored outside EXEC.
- i_memAck outside FETCH is ignored; IR is not updated.
- Timing:
  - Best-case throughput is 2 cycles per instruction (FETCH + EXEC).
  - Each wait-state cycle adds one cycle.
  - From reset deassertion to the first o_memReq is 1 cycle.
- PC wrap: PC=2^ADDR_W-1 followed by a non-halt EXEC gives PC=0.
- Reset mid-operation:
  - Mid-FETCH: o_memReq drops on that edge; a late ack is then ignored in IDLE.
  - In HALT: exits HALT; o_halted=0 on the next cycle.
- i_resume arriving together with a reset edge: reset wins.

Test Plan:
- Reset release, PC_RESET=0, zero-wait memory returning 0xA123 at addr 0:
  - o_memReq=1 with o_memAddr=0x0000 one cycle after release.
  - Next cycle: o_opcode=0xA and o_regWrEn=1 for exactly 1 cycle.
  - Then FETCH at addr 0x0001.
- Memory with 3 wait states at addr 5, returning 0x1000 (decoder i_wrReg=0):
  - o_memReq held for 4 cycles with o_memAddr=5 stable.
  - o_regWrEn stays 0; next fetch address is 6.
- HLT word 0x3000 at addr 0x0010:
  - EXEC sees i_isHLT=1, then o_halted=1 and o_memReq=0 for 20 idle cycles; PC stays 0x0010.
  - A stray i_memAck pulse leaves IR=0x3000.
  - i_resume pulse: next o_memAddr=0x0011.
- PC wrap, starting at 0xFFFF with a non-halt instruction: next fetch o_memAddr=0x0000.
- i_rstn low during FETCH wait:
  - o_memReq=0 on the next cycle; ack in IDLE is ignored.
  - After release, fetch restarts at PC_RESET with IR=0 until the first new ack.
- i_resume pulsed during FETCH and EXEC: no effect on PC, state sequence or o_halted.
